trdb_resync_ctrl: RTL



---
 rtl/trdb_pkg.sv | 21 ++
 rtl/trdb_resync_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/trdb_pkg.sv
// Shared types for the trace resync control path: request encoding toward
// the packet emitter and the state encoding of the resync control FSM.
package trdb_pkg;

    // Request kind presented to the packet emitter alongside the valid strobe.
    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_FLUSH = 2'd1,
        REQ_SYNC  = 2'd2
    } resync_req_e;

    // Resync control FSM states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLUSH_PEND = 3'd1,
        ST_SYNC_PEND  = 3'd2,
        ST_ISSUE      = 3'd3,
        ST_RST        = 3'd4
    } resync_state_e;

endpackage

// File: rtl/trdb_resync_ctrl.sv
// Resync control stage sitting after the resync counter. Watches the
// counter's threshold flags, waits for a qualified instruction, then asks
// the packet emitter for either a branch-map flush or a full sync packet.
// A completed sync request pulses the counter reset for one cycle, and
// accepted requests are folded back into the counter's packet_emitted input.
module trdb_resync_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       trace_enabled_i,
    input  logic       qualified_i,
    input  logic       branch_map_empty_i,
    input  logic       gt_resync_max_i,
    input  logic       et_resync_max_i,
    input  logic       packet_emitted_i,
    input  logic       sync_req_ready_i,
    output logic       sync_req_valid_o,
    output logic [1:0] sync_req_type_o,
    output logic       resync_rst_o,
    output logic       packet_emitted_o,
    output logic       sync_stall_o
);

    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
    localparam logic [WaitW-1:0] TimeoutCnt = WaitW'(TIMEOUT);

    resync_state_e    state_q, state_d;
    resync_req_e      type_q, type_d;
    logic             valid_q, valid_d;
    logic             rst_q, rst_d;
    logic             stall_q, stall_d;
    logic [WaitW-1:0] wait_q, wait_d;

    // Next-state logic; every output except packet_emitted_o is computed here
    // one cycle ahead so that the ports come straight from flops.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        type_d  = type_q;
        rst_d   = 1'b0;
        wait_d  = '0;
        stall_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trace_enabled_i && gt_resync_max_i) begin
                    state_d = ST_SYNC_PEND;
                end else if (trace_enabled_i && et_resync_max_i && !branch_map_empty_i) begin
                    state_d = ST_FLUSH_PEND;
                end
            end

            ST_FLUSH_PEND: begin
                if (!trace_enabled_i) begin
                    state_d = ST_IDLE;
                end else if (gt_resync_max_i) begin
                    state_d = ST_SYNC_PEND;
                end else if (qualified_i) begin
                    state_d = ST_ISSUE;
                    valid_d = 1'b1;
                    type_d  = REQ_FLUSH;
                end
            end

            ST_SYNC_PEND: begin
                if (!trace_enabled_i) begin
                    state_d = ST_IDLE;
                end else if (qualified_i) begin
                    state_d = ST_ISSUE;
                    valid_d = 1'b1;
                    type_d  = REQ_SYNC;
                end else begin
                    wait_d  = (wait_q == TimeoutCnt) ? wait_q : wait_q + WaitW'(1);
                    stall_d = (wait_q == TimeoutCnt);
                end
            end

            ST_ISSUE: begin
                if (sync_req_ready_i) begin
                    valid_d = 1'b0;
                    type_d  = REQ_NONE;
                    if (type_q == REQ_SYNC) begin
                        state_d = ST_RST;
                        rst_d   = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_RST: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                type_d  = REQ_NONE;
            end
        endcase
    end

    // State and registered outputs; reset drops everything at once, even mid-handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            type_q  <= REQ_NONE;
            valid_q <= 1'b0;
            rst_q   <= 1'b0;
            stall_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            valid_q <= valid_d;
            rst_q   <= rst_d;
            stall_q <= stall_d;
            wait_q  <= wait_d;
        end
    end

    assign sync_req_valid_o = valid_q;
    assign sync_req_type_o  = type_q;
    assign resync_rst_o     = rst_q;
    assign sync_stall_o     = stall_q;
    assign packet_emitted_o = packet_emitted_i | (valid_q & sync_req_ready_i);

endmodule
